pixel_mem_arb: RTL and testbench

PIXEL_MEM_ARB -- requirements
Module: pixel_mem_arb

---
 rtl/pixel_mem_arb.sv | 117 +++++++++++
 tb/tb_pixel_mem_arb.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_mem_arb.sv
// Single-port pixel RAM arbiter: VGA reads take absolute priority, SPI/UART writers share round-robin.
// Optional statistics counters are enabled by defining PIXEL_ARB_STATS_EN.
module pixel_mem_arb #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_rvalid,
  input  logic              spi_valid,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [DATA_W-1:0] spi_data,
  output logic              spi_ready,
  input  logic              uart_valid,
  input  logic [ADDR_W-1:0] uart_addr,
  input  logic [DATA_W-1:0] uart_data,
  output logic              uart_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef PIXEL_ARB_STATS_EN
  ,
  output logic [15:0]       spi_wr_cnt,
  output logic [15:0]       uart_wr_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int RD_LAT = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  wr_req_t spi_req, uart_req, wr_sel;
  logic    vga_gnt, spi_gnt, uart_gnt, wr_gnt;
  logic    last_uart;
  logic [RD_LAT:1] vld_pipe;

  assign spi_req  = '{addr: spi_addr,  data: spi_data};
  assign uart_req = '{addr: uart_addr, data: uart_data};

  // last_uart=1 means SPI holds the turn on the next contention
  always_comb begin
    vga_gnt  = 1'b0;
    spi_gnt  = 1'b0;
    uart_gnt = 1'b0;
    if (!rst) begin
      if (vga_req)
        vga_gnt = 1'b1;
      else if (spi_valid && (!uart_valid || last_uart))
        spi_gnt = 1'b1;
      else if (uart_valid)
        uart_gnt = 1'b1;
    end
  end

  assign wr_gnt     = spi_gnt | uart_gnt;
  assign wr_sel     = spi_gnt ? spi_req : uart_req;
  assign spi_ready  = spi_gnt;
  assign uart_ready = uart_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      last_uart <= 1'b1;
      vld_pipe  <= '0;
    end else begin
      mem_en <= vga_gnt | wr_gnt;
      mem_we <= wr_gnt;
      if (vga_gnt) begin
        mem_addr <= vga_addr;
      end else if (wr_gnt) begin
        mem_addr  <= wr_sel.addr;
        mem_wdata <= wr_sel.data;
      end
      if (wr_gnt)
        last_uart <= uart_gnt;
      vld_pipe <= {vld_pipe[RD_LAT-1:1], vga_gnt};
    end
  end

  // RAM read data is registered one cycle after mem_en, so it lines up with the pipe tail
  assign vga_rvalid = vld_pipe[RD_LAT];
  assign vga_rdata  = mem_rdata;

`ifdef PIXEL_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic stall;
  assign stall = (spi_valid & ~spi_gnt) | (uart_valid & ~uart_gnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      spi_wr_cnt  <= '0;
      uart_wr_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (spi_gnt)  spi_wr_cnt  <= sat_inc(spi_wr_cnt);
      if (uart_gnt) uart_wr_cnt <= sat_inc(uart_wr_cnt);
      if (stall)    stall_cnt   <= sat_inc(stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_pixel_mem_arb.sv
// Bench for pixel_mem_arb: directed scenarios then random traffic against a transaction-level model.
// Stats counters are checked when PIXEL_ARB_STATS_EN is defined.
module tb_pixel_mem_arb;
  localparam int AW = 15;
  localparam int DW = 15;
  localparam int RAM_N = 1024;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst, vga_req, vga_rvalid, spi_valid, spi_ready, uart_valid, uart_ready;
  logic mem_en, mem_we;
  logic [AW-1:0] vga_addr, spi_addr, uart_addr, mem_addr;
  logic [DW-1:0] vga_rdata, spi_data, uart_data, mem_wdata, mem_rdata;
`ifdef PIXEL_ARB_STATS_EN
  logic [15:0] spi_wr_cnt, uart_wr_cnt, stall_cnt;
`endif

  pixel_mem_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid),
    .spi_valid(spi_valid), .spi_addr(spi_addr), .spi_data(spi_data), .spi_ready(spi_ready),
    .uart_valid(uart_valid), .uart_addr(uart_addr), .uart_data(uart_data), .uart_ready(uart_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef PIXEL_ARB_STATS_EN
    , .spi_wr_cnt(spi_wr_cnt), .uart_wr_cnt(uart_wr_cnt), .stall_cnt(stall_cnt)
`endif
  );

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'((a * 37 + 5) & 32'h7FFF);
  endfunction

  // Synchronous single-port RAM attached to the arbiter
  logic [DW-1:0] ram [RAM_N];
  logic [DW-1:0] ram_q;
  logic          ram_load;
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < RAM_N; i++) ram[i] <= init_val(i);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
      else        ram_q <= ram[mem_addr[9:0]];
    end
  end
  assign mem_rdata = ram_q;

  // Reference model: grants applied in order to a shadow memory
  logic [DW-1:0] shadow [RAM_N];
  bit            m_spi_turn;
  bit            e_en, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  bit            rv_v [2];
  logic [DW-1:0] rv_d [2];
  bit            last_g_s, last_g_u;
  int            c_spi, c_uart, c_stall;
  int            n_tests = 0;
  int            n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are already applied (just after a falling edge); check ready, advance model, check RAM port
  task automatic tick();
    bit g_v, g_s, g_u;
    #1;
    g_v = 0; g_s = 0; g_u = 0;
    if (!rst) begin
      if (vga_req) g_v = 1;
      else if (spi_valid && uart_valid) begin
        if (m_spi_turn) g_s = 1; else g_u = 1;
      end
      else if (spi_valid)  g_s = 1;
      else if (uart_valid) g_u = 1;
    end
    chk("spi_ready", spi_ready, g_s);
    chk("uart_ready", uart_ready, g_u);
    last_g_s = g_s; last_g_u = g_u;
    rv_v[1] = rv_v[0]; rv_d[1] = rv_d[0];
    if (rst) begin
      e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0;
      rv_v[0] = 0; rv_v[1] = 0;
      m_spi_turn = 1;
      c_spi = 0; c_uart = 0; c_stall = 0;
    end else begin
      e_en = g_v | g_s | g_u;
      e_we = g_s | g_u;
      rv_v[0] = g_v;
      rv_d[0] = g_v ? shadow[vga_addr[9:0]] : '0;
      if (g_v) e_addr = vga_addr;
      if (g_s) begin
        e_addr = spi_addr; e_wdata = spi_data; shadow[spi_addr[9:0]] = spi_data;
        m_spi_turn = 0; c_spi++;
      end
      if (g_u) begin
        e_addr = uart_addr; e_wdata = uart_data; shadow[uart_addr[9:0]] = uart_data;
        m_spi_turn = 1; c_uart++;
      end
      if ((spi_valid && !g_s) || (uart_valid && !g_u)) c_stall++;
    end
    @(negedge clk);
    chk("mem_en", mem_en, e_en);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("vga_rvalid", vga_rvalid, rv_v[1]);
    if (rv_v[1]) chk("vga_rdata", vga_rdata, rv_d[1]);
  endtask

  task automatic idle();
    vga_req = 0; spi_valid = 0; uart_valid = 0;
  endtask

  initial begin
    for (int i = 0; i < RAM_N; i++) shadow[i] = init_val(i);
    rv_v[0] = 0; rv_v[1] = 0; rv_d[0] = '0; rv_d[1] = '0;
    m_spi_turn = 1;
    rst = 1; ram_load = 1; idle();
    vga_addr = '0; spi_addr = '0; spi_data = '0; uart_addr = '0; uart_data = '0;
    tick();
    ram_load = 0;
    tick();
    rst = 0;

    // Contention after reset: SPI, UART, SPI, UART
    spi_valid = 1; spi_addr = 15'h0001; spi_data = 15'h0101;
    uart_valid = 1; uart_addr = 15'h0002; uart_data = 15'h0202;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_spi", last_g_s, (i % 2 == 0));
      if (last_g_s) begin spi_addr = spi_addr + 15'd2; spi_data = spi_data + 15'd7; end
      if (last_g_u) begin uart_addr = uart_addr + 15'd2; uart_data = uart_data + 15'd9; end
    end
    uart_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      spi_addr = spi_addr + 15'd2;
    end
    spi_valid = 0; uart_valid = 1;
    tick();
    idle();
    tick();
`ifdef PIXEL_ARB_STATS_EN
    chk("spi_wr_cnt", spi_wr_cnt, 5);
    chk("uart_wr_cnt", uart_wr_cnt, 3);
    chk("stall_cnt", stall_cnt, 4);
`endif

    // Lone SPI write reaches the RAM port one cycle later
    spi_valid = 1; spi_addr = 15'h0010; spi_data = 15'h7FFF;
    tick();
    chk("w19_addr", mem_addr, 15'h0010);
    chk("w19_data", mem_wdata, 15'h7FFF);
    chk("w19_we", mem_we, 1);

    // VGA reads starve a pending SPI writer
    spi_addr = 15'h0020; spi_data = 15'h0aaa;
    vga_req = 1;
    for (int i = 0; i < 3; i++) begin
      vga_addr = AW'(i);
      tick();
    end
    vga_req = 0;
    tick();
    idle();
    tick(); tick();

    // Write then read the same pixel; then simultaneous read/write returns old data
    spi_valid = 1; spi_addr = 15'h0100; spi_data = 15'h1234;
    tick();
    idle(); vga_req = 1; vga_addr = 15'h0100;
    tick();
    idle();
    tick();
    chk("rd_after_wr", vga_rdata, 15'h1234);
    vga_req = 1; vga_addr = 15'h0200;
    spi_valid = 1; spi_addr = 15'h0200; spi_data = 15'h5555;
    tick();
    vga_req = 0;
    tick();
    chk("rd_old", vga_rdata, init_val(32'h200));
    idle();
    tick(); tick();

    // Reset one cycle after a VGA grant kills the read
    vga_req = 1; vga_addr = 15'h0033;
    tick();
    idle(); rst = 1;
    tick();
    chk("rst_rvalid", vga_rvalid, 0);
    rst = 0;
    tick();
    chk("post_rst_en", mem_en, 0);
    chk("post_rst_rvalid", vga_rvalid, 0);

    // Random traffic; writers hold their request until accepted
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 249) == 0);
      vga_req = ($urandom_range(0, 3) == 0);
      vga_addr = AW'($urandom_range(0, 63));
      if (!spi_valid || last_g_s) begin
        spi_valid = $urandom_range(0, 1);
        spi_addr = AW'($urandom_range(0, 63));
        spi_data = DW'($urandom);
      end
      if (!uart_valid || last_g_u) begin
        uart_valid = $urandom_range(0, 1);
        uart_addr = AW'($urandom_range(0, 63));
        uart_data = DW'($urandom);
      end
      tick();
    end
    rst = 0; idle();
    tick(); tick();
`ifdef PIXEL_ARB_STATS_EN
    chk("rnd_spi_cnt", spi_wr_cnt, c_spi);
    chk("rnd_uart_cnt", uart_wr_cnt, c_uart);
    chk("rnd_stall_cnt", stall_cnt, c_stall);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
